// File: rtl/cpu_pkg.sv
// Shared definitions for the 3-bit-opcode CPU core: opcodes, sequencer states
// and the opcode classifier used by the sequencer.
package cpu_pkg;

  localparam int unsigned OP_W    = 3;
  localparam int unsigned PHASE_W = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_LDI = 3'b010;
  localparam logic [OP_W-1:0] OP_XOR = 3'b011;
  localparam logic [OP_W-1:0] OP_STR = 3'b100;

  typedef enum logic [PHASE_W-1:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5
  } seq_state_t;

  // ALU ops occupy the lower half of the opcode space.
  function automatic logic op_is_alu(input logic [OP_W-1:0] op);
    return (op[OP_W-1] == 1'b0);
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Instruction/data memory request-acknowledge bundle between sequencer and memories.
interface cpu_sequencer_if;

  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  modport master (
    output imem_req,
    output dmem_req,
    output dmem_we,
    input  imem_ack,
    input  dmem_ack
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    input  dmem_we,
    output imem_ack,
    output dmem_ack
  );

endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/mem/write-back sequencer with run/halt control
// and a wrapping retired-instruction counter.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              halt,
  input  logic [OP_W-1:0]   opcode,
  cpu_sequencer_if.master   mem,
  output logic              ir_load,
  output logic              pc_inc,
  output logic              alu_latch,
  output logic              rf_we,
  output logic              busy,
  output logic              instr_done,
  output logic [PHASE_W-1:0] phase,
  output logic [CNT_W-1:0]  retired
);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;

  // State and counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Next-state and output decode; acks only matter in their own request state.
  always_comb begin
    state_d      = state_q;
    retire       = 1'b0;
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    mem.dmem_we  = 1'b0;
    ir_load      = 1'b0;
    pc_inc       = 1'b0;
    alu_latch    = 1'b0;
    rf_we        = 1'b0;
    instr_done   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (run && !halt) state_d = FETCH;
      end
      FETCH: begin
        mem.imem_req = 1'b1;
        if (mem.imem_ack) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        alu_latch = 1'b1;
        if (op_is_alu(opcode))      state_d = WB;
        else if (opcode == OP_STR)  state_d = MEM;
        else                        retire  = 1'b1;
      end
      MEM: begin
        mem.dmem_req = 1'b1;
        mem.dmem_we  = 1'b1;
        if (mem.dmem_ack) retire = 1'b1;
      end
      WB: begin
        rf_we  = 1'b1;
        retire = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Run/halt are only sampled at an instruction boundary.
    if (retire) begin
      instr_done = 1'b1;
      state_d    = (halt || !run) ? IDLE : FETCH;
    end

    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
  end

  assign busy    = (state_q != IDLE);
  assign phase   = PHASE_W'(state_q);
  assign retired = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: ALU, STR with data waits, fetch waits, halt,
// NOP, counter wrap and reset during a memory wait.
module tb_cpu_sequencer;

  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             run;
  logic             halt;
  logic [2:0]       opcode;
  logic             ir_load, pc_inc, alu_latch, rf_we, busy, instr_done;
  logic [2:0]       phase;
  logic [CNT_W-1:0] retired;

  int n_checks;
  int n_errors;
  int cnt;
  logic [CNT_W-1:0] exp_ret;

  cpu_sequencer_if mem_if ();

  cpu_sequencer #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .halt       (halt),
    .opcode     (opcode),
    .mem        (mem_if.master),
    .ir_load    (ir_load),
    .pc_inc     (pc_inc),
    .alu_latch  (alu_latch),
    .rf_we      (rf_we),
    .busy       (busy),
    .instr_done (instr_done),
    .phase      (phase),
    .retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Enter the next cycle: inputs change mid-cycle, acks default low.
  task automatic cyc();
    @(negedge clk);
    mem_if.imem_ack = 1'b0;
    mem_if.dmem_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0; run = 1'b0; halt = 1'b0; opcode = 3'b000;
    mem_if.imem_ack = 1'b0;
    mem_if.dmem_ack = 1'b0;

    // Reset state
    cyc(); #1;
    chk("rst_phase", 32'(phase), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_retired", 32'(retired), 0);
    chk("rst_imem_req", 32'(mem_if.imem_req), 0);
    chk("rst_done", 32'(instr_done), 0);

    // ADD with zero-wait memory: FETCH, DECODE, EXEC, WB
    cyc(); rst_n = 1'b1; run = 1'b1; opcode = 3'b000;
    cyc(); mem_if.imem_ack = 1'b1; #1;
    chk("add_c1_phase", 32'(phase), 1);
    chk("add_c1_ir_load", 32'(ir_load), 1);
    chk("add_c1_pc_inc", 32'(pc_inc), 1);
    cyc(); #1;
    chk("add_c2_phase", 32'(phase), 2);
    chk("add_c2_ir_load", 32'(ir_load), 0);
    cyc(); #1;
    chk("add_c3_phase", 32'(phase), 3);
    chk("add_c3_alu_latch", 32'(alu_latch), 1);
    chk("add_c3_done", 32'(instr_done), 0);
    cyc(); #1;
    chk("add_c4_phase", 32'(phase), 5);
    chk("add_c4_rf_we", 32'(rf_we), 1);
    chk("add_c4_done", 32'(instr_done), 1);
    chk("add_c4_dmem_req", 32'(mem_if.dmem_req), 0);

    // STR with data ack on the third request cycle
    cyc(); opcode = 3'b100; mem_if.imem_ack = 1'b1; #1;
    chk("str_retired_prev", 32'(retired), 1);
    chk("str_imem_req_b2b", 32'(mem_if.imem_req), 1);
    cnt = 0;
    cyc(); #1; chk("str_decode_phase", 32'(phase), 2);
    cyc(); #1; chk("str_exec_phase", 32'(phase), 3);
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (i == 2) mem_if.dmem_ack = 1'b1;
      #1;
      chk("str_mem_phase", 32'(phase), 4);
      chk("str_dmem_we", 32'(mem_if.dmem_we), 1);
      chk("str_rf_we", 32'(rf_we), 0);
      chk("str_done", 32'(instr_done), (i == 2) ? 1 : 0);
      if (mem_if.dmem_req) cnt++;
    end
    cyc(); opcode = 3'b011; #1;
    chk("str_dmem_req_cycles", 32'(cnt), 3);
    chk("str_dmem_req_after", 32'(mem_if.dmem_req), 0);
    chk("str_retired", 32'(retired), 2);

    // Fetch wait of 5 cycles then XOR; halt asserted during EXEC
    cnt = 0;
    chk("fw_c0_ir_load", 32'(ir_load), 0);
    for (int i = 1; i < 5; i++) begin
      cyc(); #1;
      chk("fw_imem_req", 32'(mem_if.imem_req), 1);
      chk("fw_phase", 32'(phase), 1);
      if (ir_load) cnt++;
    end
    cyc(); mem_if.imem_ack = 1'b1; #1;
    if (ir_load && pc_inc) cnt++;
    cyc(); #1;
    if (ir_load) cnt++;
    chk("fw_ir_load_pulses", 32'(cnt), 1);
    cyc(); halt = 1'b1; #1;
    chk("xor_exec_phase", 32'(phase), 3);
    cyc(); #1;
    chk("xor_wb_rf_we", 32'(rf_we), 1);
    chk("xor_wb_done", 32'(instr_done), 1);
    cyc(); #1;
    chk("halt_phase", 32'(phase), 0);
    chk("halt_busy", 32'(busy), 0);
    chk("halt_retired", 32'(retired), 3);
    cyc(); #1;
    chk("halt_imem_req", 32'(mem_if.imem_req), 0);
    chk("halt_stays_idle", 32'(phase), 0);

    // NOP (111) with a spurious data ack during FETCH
    halt = 1'b0; opcode = 3'b111;
    cyc(); mem_if.dmem_ack = 1'b1; #1;
    chk("nop_fetch_phase", 32'(phase), 1);
    chk("nop_spurious_dmem_req", 32'(mem_if.dmem_req), 0);
    chk("nop_spurious_done", 32'(instr_done), 0);
    cyc(); mem_if.imem_ack = 1'b1; #1;
    chk("nop_fetch_still", 32'(phase), 1);
    cyc(); #1;
    cyc(); #1;
    chk("nop_exec_done", 32'(instr_done), 1);
    chk("nop_rf_we", 32'(rf_we), 0);
    chk("nop_dmem_req", 32'(mem_if.dmem_req), 0);

    // 13 more NOPs: 17 retirements total wraps a 4-bit counter to 1
    exp_ret = 4'd4;
    for (int i = 0; i < 13; i++) begin
      cyc(); mem_if.imem_ack = 1'b1; #1;
      chk("wrap_retired", 32'(retired), 32'(exp_ret));
      cyc(); #1;
      cyc(); #1;
      chk("wrap_done", 32'(instr_done), 1);
      exp_ret = exp_ret + 4'd1;
    end

    // STR; reset asserted during data wait
    cyc(); opcode = 3'b100; mem_if.imem_ack = 1'b1; #1;
    chk("wrap_final", 32'(retired), 1);
    cyc(); #1;
    cyc(); #1;
    cyc(); #1;
    chk("rmem_dmem_req", 32'(mem_if.dmem_req), 1);
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    chk("rmem_dmem_req_drop", 32'(mem_if.dmem_req), 0);
    chk("rmem_phase", 32'(phase), 0);
    chk("rmem_retired", 32'(retired), 0);
    chk("rmem_busy", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
